multicycle_controller: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives ALUOp into the existing ALU decoder (00 add, 01 sub, 10 use funct, 11 LUI) and produces every mux select and write enable for the datapath.
- Waits on a memory-ready handshake, detects illegal opcodes, and counts retired instructions.

---
 rtl/mips_ctrl_pkg.sv | 68 ++++++
 rtl/ctrl_output_decode.sv | 73 +++++++
 rtl/multicycle_controller.sv | 109 ++++++++++
 tb/tb_multicycle_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcodes,
// ALU/mux select codes and the packed control vector.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_IWB    = 4'd10,
      S_JUMP   = 4'd11,
      S_LUIEX  = 4'd12,
      S_JR     = 4'd13
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_LUI   = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_RS     = 2'b11;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   typedef struct packed {
      logic       iord;
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic [1:0] pcsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       memwrite;
      logic       illegal;
   } ctrl_t;

   function automatic logic op_is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J) ||
             (op == OP_LUI);
   endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational Moore decode of the control vector from the current state;
// only the memory-related write enables look at MemReady.
module ctrl_output_decode
   import mips_ctrl_pkg::*;
(
   input  state_e state_i,
   input  logic   mem_ready_i,
   input  logic   op_legal_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.alusrcb = SRCB_FOUR;
            ctrl_o.irwrite = mem_ready_i;
            ctrl_o.pcwrite = mem_ready_i;
         end
         S_DECODE: begin
            ctrl_o.alusrcb = SRCB_IMMSH;
            ctrl_o.illegal = ~op_legal_i;
         end
         S_MEMADR: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_IMM;
         end
         S_MEMRD: ctrl_o.iord = 1'b1;
         S_MEMWB: begin
            ctrl_o.memtoreg = 1'b1;
            ctrl_o.regwrite = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.iord     = 1'b1;
            ctrl_o.memwrite = mem_ready_i;
         end
         S_EXEC: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.regdst   = 1'b1;
            ctrl_o.regwrite = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.aluop   = ALUOP_SUB;
            ctrl_o.pcsrc   = PCSRC_ALUOUT;
            ctrl_o.branch  = 1'b1;
         end
         S_ADDIEX: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_IMM;
         end
         S_IWB: ctrl_o.regwrite = 1'b1;
         S_JUMP: begin
            ctrl_o.pcsrc   = PCSRC_JUMP;
            ctrl_o.pcwrite = 1'b1;
         end
         S_LUIEX: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = ALUOP_LUI;
         end
         S_JR: begin
            ctrl_o.pcsrc   = PCSRC_RS;
            ctrl_o.pcwrite = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle MIPS datapath, with illegal-opcode
// detection and a retired-instruction counter.
module multicycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         Opcode,
   input  logic [5:0]         Funct,
   input  logic               MemReady,
   output logic               IorD,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               Branch,
   output logic [1:0]         PCSrc,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic               RegDst,
   output logic               MemtoReg,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic               IllegalOp,
   output logic [3:0]         State,
   output logic [COUNT_W-1:0] RetiredCount
);

   state_e               state_q, state_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 retire;
   state_e               dec_state;
   ctrl_t                ctrl;

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:  if (MemReady) state_d = S_DECODE;
         S_DECODE: begin
            case (Opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = (Funct == FN_JR) ? S_JR : S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               OP_LUI:       state_d = S_LUIEX;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (MemReady) state_d = S_MEMWB;
         S_MEMWR: begin
            if (MemReady) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_IWB;
         S_LUIEX:  state_d = S_IWB;
         S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP, S_JR: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default:  state_d = S_FETCH;
      endcase
      count_d = retire ? count_q + COUNT_W'(1) : count_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Under reset the datapath sees FETCH controls with every write enable off,
   // even before the synchronous reset has taken effect on state_q.
   assign dec_state = reset ? S_FETCH : state_q;

   ctrl_output_decode u_decode (
      .state_i     (dec_state),
      .mem_ready_i (MemReady),
      .op_legal_i  (op_is_legal(Opcode)),
      .ctrl_o      (ctrl)
   );

   assign IorD         = ctrl.iord;
   assign PCSrc        = ctrl.pcsrc;
   assign ALUSrcA      = ctrl.alusrca;
   assign ALUSrcB      = ctrl.alusrcb;
   assign ALUOp        = ctrl.aluop;
   assign RegDst       = ctrl.regdst;
   assign MemtoReg     = ctrl.memtoreg;
   assign IRWrite      = ctrl.irwrite  & ~reset;
   assign PCWrite      = ctrl.pcwrite  & ~reset;
   assign Branch       = ctrl.branch   & ~reset;
   assign RegWrite     = ctrl.regwrite & ~reset;
   assign MemWrite     = ctrl.memwrite & ~reset;
   assign IllegalOp    = ctrl.illegal  & ~reset;
   assign State        = state_q;
   assign RetiredCount = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with a 2-bit retire counter so
// that counter wrap is exercised alongside normal instruction flow.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Opcode, Funct;
   logic       MemReady;
   logic       IorD, IRWrite, PCWrite, Branch;
   logic [1:0] PCSrc, ALUSrcB, ALUOp;
   logic       ALUSrcA, RegDst, MemtoReg, RegWrite, MemWrite, IllegalOp;
   logic [3:0] State;
   logic [1:0] RetiredCount;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.COUNT_W(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .Opcode       (Opcode),
      .Funct        (Funct),
      .MemReady     (MemReady),
      .IorD         (IorD),
      .IRWrite      (IRWrite),
      .PCWrite      (PCWrite),
      .Branch       (Branch),
      .PCSrc        (PCSrc),
      .ALUSrcA      (ALUSrcA),
      .ALUSrcB      (ALUSrcB),
      .ALUOp        (ALUOp),
      .RegDst       (RegDst),
      .MemtoReg     (MemtoReg),
      .RegWrite     (RegWrite),
      .MemWrite     (MemWrite),
      .IllegalOp    (IllegalOp),
      .State        (State),
      .RetiredCount (RetiredCount)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step_state(input string tag, input logic [3:0] exp);
      tick();
      check_eq(tag, 32'(State), 32'(exp));
   endtask

   initial begin
      reset = 1'b1; MemReady = 1'b1; Opcode = 6'b000000; Funct = 6'b100010;
      tick(); tick();
      reset = 1'b0;
      check_eq("init_state", 32'(State), 0);
      check_eq("init_count", 32'(RetiredCount), 0);

      // Walk into EXEC, then reset from there.
      step_state("pre_dec", 1);
      step_state("pre_exec", 6);
      reset = 1'b1; #1;
      check_eq("rst_aluop_fetch", 32'(ALUOp), 0);
      check_eq("rst_srcb_fetch", 32'(ALUSrcB), 1);
      check_eq("rst_pcwrite_pre", 32'(PCWrite), 0);
      check_eq("rst_irwrite_pre", 32'(IRWrite), 0);
      tick(); tick();
      check_eq("rst_state", 32'(State), 0);
      check_eq("rst_count", 32'(RetiredCount), 0);
      check_eq("rst_regwrite", 32'(RegWrite), 0);
      check_eq("rst_irwrite", 32'(IRWrite), 0);
      check_eq("rst_pcwrite", 32'(PCWrite), 0);
      reset = 1'b0; #1;
      check_eq("fetch_irwrite", 32'(IRWrite), 1);
      check_eq("fetch_pcwrite", 32'(PCWrite), 1);

      // FETCH stalls while memory is not ready.
      MemReady = 1'b0; #1;
      check_eq("fetch_wait_irw", 32'(IRWrite), 0);
      step_state("fetch_wait", 0);
      MemReady = 1'b1;

      // lw
      Opcode = 6'b100011;
      step_state("lw_dec", 1);
      check_eq("lw_dec_srcb", 32'(ALUSrcB), 3);
      step_state("lw_madr", 2);
      step_state("lw_mrd", 3);
      check_eq("lw_mrd_iord", 32'(IorD), 1);
      step_state("lw_mwb", 4);
      check_eq("lw_regwrite", 32'(RegWrite), 1);
      check_eq("lw_memtoreg", 32'(MemtoReg), 1);
      check_eq("lw_regdst", 32'(RegDst), 0);
      step_state("lw_fetch", 0);
      check_eq("lw_count", 32'(RetiredCount), 1);

      // sw with a three-cycle memory wait
      Opcode = 6'b101011;
      step_state("sw_dec", 1);
      step_state("sw_madr", 2);
      MemReady = 1'b0;
      step_state("sw_mwr", 5);
      for (int i = 0; i < 3; i++) begin
         check_eq("sw_wait_state", 32'(State), 5);
         check_eq("sw_wait_memwrite", 32'(MemWrite), 0);
         tick();
      end
      check_eq("sw_still_wait", 32'(State), 5);
      MemReady = 1'b1; #1;
      check_eq("sw_memwrite", 32'(MemWrite), 1);
      check_eq("sw_iord", 32'(IorD), 1);
      step_state("sw_fetch", 0);
      check_eq("sw_count", 32'(RetiredCount), 2);

      // R-type sub
      Opcode = 6'b000000; Funct = 6'b100010;
      step_state("r_dec", 1);
      step_state("r_exec", 6);
      check_eq("r_aluop", 32'(ALUOp), 2);
      check_eq("r_srca", 32'(ALUSrcA), 1);
      check_eq("r_srcb", 32'(ALUSrcB), 0);
      step_state("r_wb", 7);
      check_eq("r_regdst", 32'(RegDst), 1);
      check_eq("r_regwrite", 32'(RegWrite), 1);
      step_state("r_fetch", 0);
      check_eq("r_count", 32'(RetiredCount), 3);

      // jr: count wraps 3 -> 0
      Funct = 6'b001000;
      step_state("jr_dec", 1);
      step_state("jr_exec", 13);
      check_eq("jr_pcsrc", 32'(PCSrc), 3);
      check_eq("jr_pcwrite", 32'(PCWrite), 1);
      step_state("jr_fetch", 0);
      check_eq("jr_count", 32'(RetiredCount), 0);

      // lui
      Opcode = 6'b001111;
      step_state("lui_dec", 1);
      step_state("lui_ex", 12);
      check_eq("lui_aluop", 32'(ALUOp), 3);
      check_eq("lui_srcb", 32'(ALUSrcB), 2);
      check_eq("lui_srca", 32'(ALUSrcA), 1);
      step_state("lui_wb", 10);
      check_eq("lui_regwrite", 32'(RegWrite), 1);
      check_eq("lui_regdst", 32'(RegDst), 0);
      check_eq("lui_memtoreg", 32'(MemtoReg), 0);
      step_state("lui_fetch", 0);
      check_eq("lui_count", 32'(RetiredCount), 1);

      // addi
      Opcode = 6'b001000;
      step_state("addi_dec", 1);
      step_state("addi_ex", 9);
      check_eq("addi_srcb", 32'(ALUSrcB), 2);
      check_eq("addi_aluop", 32'(ALUOp), 0);
      step_state("addi_wb", 10);
      step_state("addi_fetch", 0);
      check_eq("addi_count", 32'(RetiredCount), 2);

      // j
      Opcode = 6'b000010;
      step_state("j_dec", 1);
      step_state("j_jump", 11);
      check_eq("j_pcsrc", 32'(PCSrc), 2);
      check_eq("j_pcwrite", 32'(PCWrite), 1);
      step_state("j_fetch", 0);
      check_eq("j_count", 32'(RetiredCount), 3);

      // Illegal opcode returns to FETCH without retiring
      Opcode = 6'b111111;
      step_state("ill_dec", 1);
      check_eq("ill_flag", 32'(IllegalOp), 1);
      step_state("ill_fetch", 0);
      check_eq("ill_count", 32'(RetiredCount), 3);
      check_eq("ill_flag_clear", 32'(IllegalOp), 0);

      // Four beq after a fresh reset: count 1,2,3,0
      reset = 1'b1; tick(); reset = 1'b0;
      Opcode = 6'b000100;
      for (int n = 1; n <= 4; n++) begin
         step_state("beq_dec", 1);
         step_state("beq_br", 8);
         check_eq("beq_branch", 32'(Branch), 1);
         check_eq("beq_aluop", 32'(ALUOp), 1);
         check_eq("beq_pcsrc", 32'(PCSrc), 1);
         step_state("beq_fetch", 0);
         check_eq("beq_count", 32'(RetiredCount), 32'(n % 4));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
